// File: rtl/fifo_share_pkg.sv
// Shared constants and small helpers for the two-writer / one-reader FIFO
// sharing controller and its output buffer.
package fifo_share_pkg;

  localparam int DAT_WIDTH    = 32;
  localparam int PTR_WIDTH    = 5;
  localparam int SKID_DEPTH   = 2;

  localparam int ERR_WR_FULL  = 0;
  localparam int ERR_RD_EMPTY = 1;

  typedef logic [1:0] occ_t;

  // True when a new read can be issued without the buffer overflowing once
  // everything already requested has landed (occ + inflight - pop < 2).
  function automatic logic rd_room(input occ_t occ, input logic inflight, input logic pop);
    logic [2:0] committed;
    logic [2:0] limit;
    committed = 3'(occ) + 3'(inflight);
    limit     = 3'(SKID_DEPTH) + 3'(pop);
    return committed < limit;
  endfunction

  // Sticky error update: a new error pulse takes priority over a clear.
  function automatic logic [1:0] sticky_next(input logic [1:0] cur,
                                             input logic       wr_err,
                                             input logic       rd_err,
                                             input logic       clr);
    logic [1:0] set;
    set               = 2'b00;
    set[ERR_WR_FULL]  = wr_err;
    set[ERR_RD_EMPTY] = rd_err;
    return (clr ? 2'b00 : cur) | set;
  endfunction

endpackage

// File: rtl/fifo_out_skid2.sv
// Two-entry output buffer that turns the FIFO's delayed read data into a
// valid/ready stream while preserving order.
module fifo_out_skid2 #(
  parameter int DAT_WIDTH = fifo_share_pkg::DAT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 push_i,
  input  logic [DAT_WIDTH-1:0] push_data_i,
  input  logic                 pop_i,
  output logic [1:0]           occ_o,
  output logic                 valid_o,
  output logic [DAT_WIDTH-1:0] head_data_o
);
  import fifo_share_pkg::*;

  logic [DAT_WIDTH-1:0] mem_q [SKID_DEPTH];
  logic                 head_q, head_d;
  logic                 tail_q, tail_d;
  occ_t                 occ_q, occ_d;
  logic                 do_pop;

  assign do_pop = pop_i && (occ_q != 2'd0);

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (push_i) tail_d = ~tail_q;
    if (do_pop) head_d = ~head_q;
    case ({push_i, do_pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q <= 1'b0;
      tail_q <= 1'b0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by occ_q.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[tail_q] <= push_data_i;
  end

  assign occ_o       = occ_q;
  assign valid_o     = (occ_q != 2'd0);
  assign head_data_o = mem_q[head_q];

endmodule

// File: rtl/fifo_a32d32_share_ctrl.sv
// Shares one 32x32 FIFO envelope between two round-robin writers and a single
// valid/ready reader that hides the envelope's one-cycle read latency.
module fifo_a32d32_share_ctrl #(
  parameter int DAT_WIDTH = fifo_share_pkg::DAT_WIDTH,
  parameter int PTR_WIDTH = fifo_share_pkg::PTR_WIDTH,
  parameter int AF_THRESH = 28
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req0_valid,
  input  logic [DAT_WIDTH-1:0] req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [DAT_WIDTH-1:0] req1_data,
  output logic                 req1_ready,
  output logic                 out_valid,
  output logic [DAT_WIDTH-1:0] out_data,
  input  logic                 out_ready,
  output logic                 fifo_wr_op,
  output logic [DAT_WIDTH-1:0] fifo_wr_data,
  output logic [DAT_WIDTH-1:0] fifo_wr_mask,
  output logic                 fifo_rd_op,
  input  logic [DAT_WIDTH-1:0] fifo_rd_data,
  input  logic                 fifo_full,
  input  logic                 fifo_empty,
  input  logic [PTR_WIDTH:0]   fifo_entry_used,
  input  logic                 fifo_wr_full_err,
  input  logic                 fifo_rd_empty_err,
  output logic                 almost_full,
  output logic [1:0]           err_sticky,
  input  logic                 err_clr
);
  import fifo_share_pkg::*;

  // last_grant_q holds the index of the requester that transferred last.
  logic       last_grant_q, last_grant_d;
  logic       elig0, elig1;
  logic       gnt0, gnt1;

  logic       inflight_q;
  occ_t       occ;
  logic       pop;
  logic       rd_issue;

  logic       almost_full_q, almost_full_d;
  logic [1:0] err_sticky_q, err_sticky_d;

  always_comb begin
    elig0        = reset_n && req0_valid && !fifo_full;
    elig1        = reset_n && req1_valid && !fifo_full;
    gnt0         = elig0 && (!elig1 || last_grant_q);
    gnt1         = elig1 && (!elig0 || !last_grant_q);
    last_grant_d = last_grant_q;
    if (gnt0)      last_grant_d = 1'b0;
    else if (gnt1) last_grant_d = 1'b1;
  end

  assign req0_ready   = gnt0;
  assign req1_ready   = gnt1;
  assign fifo_wr_op   = gnt0 | gnt1;
  assign fifo_wr_data = gnt1 ? req1_data : req0_data;
  assign fifo_wr_mask = '1;

  assign pop        = out_valid && out_ready;
  assign rd_issue   = reset_n && !fifo_empty && rd_room(occ, inflight_q, pop);
  assign fifo_rd_op = rd_issue;

  always_comb begin
    almost_full_d = (fifo_entry_used >= (PTR_WIDTH+1)'(AF_THRESH));
    err_sticky_d  = sticky_next(err_sticky_q, fifo_wr_full_err, fifo_rd_empty_err, err_clr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q  <= 1'b1;
      inflight_q    <= 1'b0;
      almost_full_q <= 1'b0;
      err_sticky_q  <= 2'b00;
    end else begin
      last_grant_q  <= last_grant_d;
      inflight_q    <= rd_issue;
      almost_full_q <= almost_full_d;
      err_sticky_q  <= err_sticky_d;
    end
  end

  assign almost_full = almost_full_q;
  assign err_sticky  = err_sticky_q;

  // The envelope presents read data the cycle after rd_op; capture it then.
  fifo_out_skid2 #(
    .DAT_WIDTH (DAT_WIDTH)
  ) u_skid (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (inflight_q),
    .push_data_i (fifo_rd_data),
    .pop_i       (pop),
    .occ_o       (occ),
    .valid_o     (out_valid),
    .head_data_o (out_data)
  );

endmodule

// File: tb/tb_fifo_a32d32_share_ctrl.sv
// Bench for fifo_a32d32_share_ctrl: a behavioural FIFO envelope plus a
// queue-based reference of arbitration order and delivered data.
module tb_fifo_a32d32_share_ctrl;
  localparam int DW    = 32;
  localparam int PW    = 5;
  localparam int AF    = 28;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [DW-1:0] req0_data = '0, req1_data = '0;
  logic          req0_ready, req1_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic          fifo_wr_op, fifo_rd_op;
  logic [DW-1:0] fifo_wr_data, fifo_wr_mask;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_full, fifo_empty;
  logic [PW:0]   fifo_entry_used;
  logic          fifo_wr_full_err, fifo_rd_empty_err;
  logic          almost_full;
  logic [1:0]    err_sticky;
  logic          err_clr = 1'b0;
  logic          force_wr_err = 1'b0, force_rd_err = 1'b0;

  always #5 clk = ~clk;

  fifo_a32d32_share_ctrl #(.DAT_WIDTH(DW), .PTR_WIDTH(PW), .AF_THRESH(AF)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .fifo_wr_op(fifo_wr_op), .fifo_wr_data(fifo_wr_data), .fifo_wr_mask(fifo_wr_mask),
    .fifo_rd_op(fifo_rd_op), .fifo_rd_data(fifo_rd_data),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_entry_used(fifo_entry_used),
    .fifo_wr_full_err(fifo_wr_full_err), .fifo_rd_empty_err(fifo_rd_empty_err),
    .almost_full(almost_full), .err_sticky(err_sticky), .err_clr(err_clr)
  );

  // Behavioural FIFO envelope: registered flags, one-cycle read latency.
  logic [DW-1:0] env_mem [DEPTH];
  logic [PW-1:0] env_wp, env_rp;
  logic [PW:0]   env_cnt;
  logic          env_wr_err, env_rd_err;

  assign fifo_full         = (env_cnt == (PW+1)'(DEPTH));
  assign fifo_empty        = (env_cnt == '0);
  assign fifo_entry_used   = env_cnt;
  assign fifo_wr_full_err  = env_wr_err | force_wr_err;
  assign fifo_rd_empty_err = env_rd_err | force_rd_err;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      env_wp <= '0; env_rp <= '0; env_cnt <= '0;
      env_wr_err <= 1'b0; env_rd_err <= 1'b0;
    end else begin
      env_wr_err <= fifo_wr_op && fifo_full;
      env_rd_err <= fifo_rd_op && fifo_empty;
      if (fifo_wr_op && !fifo_full) begin
        env_mem[env_wp] <= fifo_wr_data;
        env_wp <= env_wp + 1'b1;
      end
      if (fifo_rd_op && !fifo_empty) begin
        fifo_rd_data <= env_mem[env_rp];
        env_rp <= env_rp + 1'b1;
      end
      env_cnt <= env_cnt + (PW+1)'(fifo_wr_op && !fifo_full) - (PW+1)'(fifo_rd_op && !fifo_empty);
    end
  end

  // Reference: arbitration decided from the rules, accepted words queued in
  // acceptance order, reads outstanding counted as issued minus delivered.
  int            nvec = 0;
  int            nerr = 0;
  logic          last_m = 1'b1;
  logic          exp_g0, exp_g1, exp_pop;
  logic [DW-1:0] exp_q [$];
  int            pend = 0;
  logic [PW:0]   prev_cnt = '0;

  task automatic model_clear();
    exp_q.delete();
    last_m   = 1'b1;
    pend     = 0;
    prev_cnt = '0;
  endtask

  task automatic sample();
    logic e0, e1;
    @(negedge clk);
    e0      = req0_valid && !fifo_full;
    e1      = req1_valid && !fifo_full;
    exp_g0  = reset_n && e0 && (!e1 || last_m);
    exp_g1  = reset_n && e1 && (!e0 || !last_m);
    exp_pop = out_valid && out_ready;
  endtask

  task automatic commit();
    if (exp_pop && exp_q.size() > 0) void'(exp_q.pop_front());
    if (exp_g0) begin exp_q.push_back(req0_data); last_m = 1'b0; end
    else if (exp_g1) begin exp_q.push_back(req1_data); last_m = 1'b1; end
    pend     = pend + int'(fifo_rd_op) - int'(exp_pop);
    prev_cnt = fifo_entry_used;
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_drain(input string tag);
    int guard;
    req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b1;
    guard = 0;
    while ((exp_q.size() > 0 || pend > 0) && guard < 200) begin
      sample();
      if (exp_pop) begin
        nvec++;
        if (exp_q.size() == 0) begin
          nerr++; $display("FAIL %s drain extra beat: got %h expected none", tag, out_data);
        end else if (out_data !== exp_q[0]) begin
          nerr++; $display("FAIL %s drain data: got %h expected %h", tag, out_data, exp_q[0]);
        end
      end
      commit();
      guard++;
    end
    nvec++;
    if (exp_q.size() != 0 || out_valid !== 1'b0 || fifo_empty !== 1'b1) begin
      nerr++; $display("FAIL %s drain end: left %0d words out_valid %b empty %b expected 0/0/1",
                       tag, exp_q.size(), out_valid, fifo_empty);
    end
  endtask

  task automatic test_reset();
    req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b1;
    req0_data = $urandom; req1_data = $urandom;
    reset_n = 1'b0;
    model_clear();
    repeat (2) @(posedge clk); #1;
    nvec++;
    if ({req0_ready, req1_ready, out_valid, fifo_wr_op, fifo_rd_op, almost_full, err_sticky} !== 8'b0) begin
      nerr++; $display("FAIL reset outputs: got %b expected 00000000",
                       {req0_ready, req1_ready, out_valid, fifo_wr_op, fifo_rd_op, almost_full, err_sticky});
    end
    reset_n = 1'b1;
    sample();
    nvec++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      nerr++; $display("FAIL reset first grant: got %b%b expected 10", req0_ready, req1_ready);
    end
    commit();
    for (int k = 0; k < 5; k++) begin
      req0_data = $urandom; req1_data = $urandom;
      sample();
      nvec++;
      if (req0_ready !== exp_g0 || req1_ready !== exp_g1) begin
        nerr++; $display("FAIL reset run grant: got %b%b expected %b%b", req0_ready, req1_ready, exp_g0, exp_g1);
      end
      commit();
    end
    // Asynchronous assertion in the middle of a cycle with reads in flight.
    #2 reset_n = 1'b0;
    #1;
    nvec++;
    if ({req0_ready, req1_ready, out_valid, fifo_wr_op, fifo_rd_op, almost_full, err_sticky} !== 8'b0) begin
      nerr++; $display("FAIL reset async outputs: got %b expected 00000000",
                       {req0_ready, req1_ready, out_valid, fifo_wr_op, fifo_rd_op, almost_full, err_sticky});
    end
    model_clear();
    @(posedge clk); #1 reset_n = 1'b1;
    sample();
    nvec++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || out_valid !== 1'b0) begin
      nerr++; $display("FAIL reset re-release: got rdy %b%b vld %b expected 10 0", req0_ready, req1_ready, out_valid);
    end
    commit();
    test_drain("reset");
  endtask

  task automatic test_contention();
    int a, b;
    logic [DW-1:0] exp_wd;
    apply_reset();
    out_ready = 1'b1;
    a = 0; b = 0;
    for (int k = 0; k < 16; k++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_data = 32'hA0 + a; req1_data = 32'hB0 + b;
      exp_wd = (k % 2 == 0) ? 32'hA0 + k/2 : 32'hB0 + k/2;
      sample();
      nvec++;
      if (fifo_wr_op !== 1'b1 || fifo_wr_data !== exp_wd) begin
        nerr++; $display("FAIL contention write %0d: got op %b data %h expected 1 %h", k, fifo_wr_op, fifo_wr_data, exp_wd);
      end
      nvec++;
      if (req0_ready !== exp_g0 || req1_ready !== exp_g1) begin
        nerr++; $display("FAIL contention grant: got %b%b expected %b%b", req0_ready, req1_ready, exp_g0, exp_g1);
      end
      if (exp_pop) begin
        nvec++;
        if (exp_q.size() == 0 || out_data !== exp_q[0]) begin
          nerr++; $display("FAIL contention out: got %h expected %h", out_data, (exp_q.size() > 0) ? exp_q[0] : 'x);
        end
      end
      if (exp_g0) a++;
      if (exp_g1) b++;
      commit();
    end
    test_drain("contention");
  endtask

  // Edges counted from the write edge N: rd_op is driven in the cycle after
  // that edge, the envelope returns data at edge N+1, and out_valid is set
  // by edge N+2.
  task automatic test_latency();
    logic [DW-1:0] val;
    val = $urandom;
    out_ready = 1'b1;
    req0_valid = 1'b1; req0_data = val;
    sample();
    nvec++;
    if (fifo_wr_op !== 1'b1 || fifo_rd_op !== 1'b0 || out_valid !== 1'b0) begin
      nerr++; $display("FAIL latency write cycle: got wr %b rd %b vld %b expected 1 0 0", fifo_wr_op, fifo_rd_op, out_valid);
    end
    commit();
    req0_valid = 1'b0;
    sample();
    nvec++;
    if (fifo_rd_op !== 1'b1 || out_valid !== 1'b0) begin
      nerr++; $display("FAIL latency read issue: got rd %b vld %b expected 1 0", fifo_rd_op, out_valid);
    end
    commit();
    sample();
    nvec++;
    if (fifo_rd_op !== 1'b0 || out_valid !== 1'b0) begin
      nerr++; $display("FAIL latency capture cycle: got rd %b vld %b expected 0 0", fifo_rd_op, out_valid);
    end
    commit();
    sample();
    nvec++;
    if (out_valid !== 1'b1 || out_data !== val || fifo_rd_empty_err !== 1'b0) begin
      nerr++; $display("FAIL latency output: got vld %b data %h rderr %b expected 1 %h 0",
                       out_valid, out_data, fifo_rd_empty_err, val);
    end
    commit();
    test_drain("latency");
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    for (int k = 0; k < 60; k++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_data = $urandom; req1_data = $urandom;
      sample();
      nvec++;
      if (req0_ready !== exp_g0 || req1_ready !== exp_g1) begin
        nerr++; $display("FAIL full grant: got %b%b expected %b%b", req0_ready, req1_ready, exp_g0, exp_g1);
      end
      nvec++;
      if (almost_full !== (prev_cnt >= (PW+1)'(AF))) begin
        nerr++; $display("FAIL full almost_full: got %b expected %b (prev used %0d)", almost_full, prev_cnt >= (PW+1)'(AF), prev_cnt);
      end
      nvec++;
      if ((fifo_full && fifo_wr_op) || fifo_wr_full_err !== 1'b0) begin
        nerr++; $display("FAIL full write while full: got wr %b err %b expected 0 0", fifo_wr_op, fifo_wr_full_err);
      end
      commit();
    end
    sample();
    nvec++;
    if (fifo_full !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0 || fifo_wr_op !== 1'b0 || almost_full !== 1'b1) begin
      nerr++; $display("FAIL full steady: got full %b rdy %b%b wr %b af %b expected 1 00 0 1",
                       fifo_full, req0_ready, req1_ready, fifo_wr_op, almost_full);
    end
    commit();
    test_drain("full");
  endtask

  task automatic test_backpressure();
    int sent, guard;
    sent = 0; guard = 0;
    while ((sent < 10 || exp_q.size() > 0 || pend > 0) && guard < 100) begin
      out_ready  = guard[0];
      req0_valid = (sent < 10); req1_valid = 1'b0;
      req0_data  = $urandom;
      sample();
      nvec++;
      if (req0_ready !== exp_g0) begin
        nerr++; $display("FAIL backpressure grant: got %b expected %b", req0_ready, exp_g0);
      end
      nvec++;
      if (pend > 2 || (fifo_rd_op && (pend - int'(exp_pop)) >= 2)) begin
        nerr++; $display("FAIL backpressure overrun: got outstanding %0d rd %b pop %b expected outstanding after issue <= 2",
                         pend, fifo_rd_op, exp_pop);
      end
      if (exp_pop) begin
        nvec++;
        if (exp_q.size() == 0 || out_data !== exp_q[0]) begin
          nerr++; $display("FAIL backpressure out: got %h expected %h", out_data, (exp_q.size() > 0) ? exp_q[0] : 'x);
        end
      end
      if (exp_g0) sent++;
      commit();
      guard++;
    end
    nvec++;
    if (sent != 10 || exp_q.size() != 0) begin
      nerr++; $display("FAIL backpressure complete: got sent %0d left %0d expected 10 0", sent, exp_q.size());
    end
  endtask

  task automatic test_errors();
    req0_valid = 1'b0; req1_valid = 1'b0;
    force_rd_err = 1'b1; err_clr = 1'b1;
    sample();
    nvec++;
    if (err_sticky !== 2'b00) begin
      nerr++; $display("FAIL errors lag: got %b expected 00", err_sticky);
    end
    commit();
    force_rd_err = 1'b0; err_clr = 1'b0;
    sample();
    nvec++;
    if (err_sticky !== 2'b10) begin
      nerr++; $display("FAIL errors set beats clear: got %b expected 10", err_sticky);
    end
    commit();
    sample();
    nvec++;
    if (err_sticky !== 2'b10) begin
      nerr++; $display("FAIL errors hold: got %b expected 10", err_sticky);
    end
    err_clr = 1'b1;
    commit();
    err_clr = 1'b0; force_wr_err = 1'b1;
    sample();
    nvec++;
    if (err_sticky !== 2'b00) begin
      nerr++; $display("FAIL errors clear: got %b expected 00", err_sticky);
    end
    commit();
    force_wr_err = 1'b0;
    sample();
    nvec++;
    if (err_sticky !== 2'b01) begin
      nerr++; $display("FAIL errors wr bit: got %b expected 01", err_sticky);
    end
    err_clr = 1'b1;
    commit();
    err_clr = 1'b0;
    sample();
    nvec++;
    if (err_sticky !== 2'b00) begin
      nerr++; $display("FAIL errors wr clear: got %b expected 00", err_sticky);
    end
    commit();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_data  = $urandom; req1_data = $urandom;
      out_ready  = (k < 150) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
      sample();
      nvec++;
      if (req0_ready !== exp_g0 || req1_ready !== exp_g1 || fifo_wr_op !== (exp_g0 | exp_g1)) begin
        nerr++; $display("FAIL random grant: got %b%b wr %b expected %b%b", req0_ready, req1_ready, fifo_wr_op, exp_g0, exp_g1);
      end
      nvec++;
      if (almost_full !== (prev_cnt >= (PW+1)'(AF)) || pend > 2) begin
        nerr++; $display("FAIL random status: got af %b outstanding %0d expected af %b outstanding <= 2",
                         almost_full, pend, prev_cnt >= (PW+1)'(AF));
      end
      if (exp_pop) begin
        nvec++;
        if (exp_q.size() == 0 || out_data !== exp_q[0]) begin
          nerr++; $display("FAIL random out: got %h expected %h", out_data, (exp_q.size() > 0) ? exp_q[0] : 'x);
        end
      end
      commit();
    end
    test_drain("random");
  endtask

  initial begin
    #1;
    test_reset();
    test_contention();
    test_latency();
    test_full();
    test_backpressure();
    test_errors();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "time limit");
  end

endmodule
